// File: rtl/regfile_pkg.sv
// Shared definitions for the 32 x 64-bit register bank (read and write sides).
package regfile_pkg;

  localparam int unsigned REG_W    = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [4:0]  ZERO_REG = 5'd31;

  typedef logic [4:0]       reg_addr_t;
  typedef logic [REG_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_operand_sel.sv
// Combinational operand select for one read port.
// The hardwired zero register outranks the same-edge write bypass.
module regfile_operand_sel
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_W,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] register_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  logic                            wr_en_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  output logic [DATA_W-1:0]               data_o
);

  always_comb begin
    data_o = register_i[addr_i];
    if (addr_i == ADDR_W'(ZERO_REG)) begin
      data_o = '0;
    end else if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
  end

endmodule : regfile_operand_sel

// File: rtl/regfile_read_port.sv
// Two-port registered, stallable read stage of the register bank.
// While stalled, the data registers keep reloading from the held addresses.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_W,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] register,
  input  logic                            rd_valid,
  input  logic [ADDR_W-1:0]               rn_addr,
  input  logic [ADDR_W-1:0]               rm_addr,
  input  logic                            stall,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               rn_data,
  output logic [DATA_W-1:0]               rm_data,
  output logic                            out_valid
);

  logic [ADDR_W-1:0] rn_addr_q, rn_addr_d;
  logic [ADDR_W-1:0] rm_addr_q, rm_addr_d;
  logic [DATA_W-1:0] rn_data_q, rn_data_d;
  logic [DATA_W-1:0] rm_data_q, rm_data_d;
  logic              valid_q, valid_d;

  // Stall selects the held request; otherwise the new one is taken.
  always_comb begin
    rn_addr_d = rn_addr;
    rm_addr_d = rm_addr;
    valid_d   = rd_valid;
    if (stall) begin
      rn_addr_d = rn_addr_q;
      rm_addr_d = rm_addr_q;
      valid_d   = valid_q;
    end
  end

  regfile_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_rn (
    .register_i (register),
    .addr_i     (rn_addr_d),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .data_o     (rn_data_d)
  );

  regfile_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_rm (
    .register_i (register),
    .addr_i     (rm_addr_d),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .data_o     (rm_data_d)
  );

  // Held addresses reset to the zero register so a post-reset stall yields zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rn_addr_q <= ADDR_W'(ZERO_REG);
      rm_addr_q <= ADDR_W'(ZERO_REG);
      rn_data_q <= '0;
      rm_data_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      rn_addr_q <= rn_addr_d;
      rm_addr_q <= rm_addr_d;
      rn_data_q <= rn_data_d;
      rm_data_q <= rm_data_d;
      valid_q   <= valid_d;
    end
  end

  assign rn_data   = rn_data_q;
  assign rm_data   = rm_data_q;
  assign out_valid = valid_q;

endmodule : regfile_read_port

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: one task per scenario, inline checks.
module tb_regfile_read_port;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [31:0][63:0]     register;
  logic                  rd_valid;
  logic [4:0]            rn_addr;
  logic [4:0]            rm_addr;
  logic                  stall;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [63:0]           wr_data;
  logic [63:0]           rn_data;
  logic [63:0]           rm_data;
  logic                  out_valid;

  int errors = 0;
  int checks = 0;

  regfile_read_port dut (
    .clk       (clk),
    .reset     (reset),
    .register  (register),
    .rd_valid  (rd_valid),
    .rn_addr   (rn_addr),
    .rm_addr   (rm_addr),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rn_data   (rn_data),
    .rm_data   (rm_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (rn_data !== 64'h0 || rm_data !== 64'h0) begin
      errors++; $display("FAIL reset_data: got rn=%h rm=%h expected 0/0", rn_data, rm_data);
    end
    reset = 1'b0;
    stall = 1'b1;
    rd_valid = 1'b1;
    rn_addr = 5'd3;
    rm_addr = 5'd7;
    tick();
    checks++;
    if (rn_data !== 64'h0 || rm_data !== 64'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_stall_zero: got rn=%h rm=%h v=%b expected 0/0/0", rn_data, rm_data, out_valid);
    end
    stall = 1'b0;
  endtask

  task automatic test_basic_read();
    register[3] = 64'h11;
    register[7] = 64'h22;
    rn_addr = 5'd3; rm_addr = 5'd7; rd_valid = 1'b1;
    tick();
    checks++;
    if (rn_data !== 64'h11) begin
      errors++; $display("FAIL basic_rn: got %h expected %h", rn_data, 64'h11);
    end
    checks++;
    if (rm_data !== 64'h22) begin
      errors++; $display("FAIL basic_rm: got %h expected %h", rm_data, 64'h22);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got %b expected 1", out_valid);
    end
  endtask

  task automatic test_zero_reg();
    register[31] = 64'hBAD0_BAD0;
    rn_addr = 5'd31; rm_addr = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
    tick();
    checks++;
    if (rn_data !== 64'h0 || rm_data !== 64'h0) begin
      errors++; $display("FAIL zero_reg: got rn=%h rm=%h expected 0/0", rn_data, rm_data);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_bypass();
    register[5] = 64'h1;
    register[6] = 64'h66;
    rn_addr = 5'd5; rm_addr = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
    tick();
    checks++;
    if (rn_data !== 64'hDEAD || rm_data !== 64'hDEAD) begin
      errors++; $display("FAIL bypass_same: got rn=%h rm=%h expected DEAD/DEAD", rn_data, rm_data);
    end
    register[5] = 64'hDEAD;
    rn_addr = 5'd5; rm_addr = 5'd6;
    wr_addr = 5'd6; wr_data = 64'hBEEF;
    tick();
    checks++;
    if (rn_data !== 64'hDEAD || rm_data !== 64'hBEEF) begin
      errors++; $display("FAIL bypass_one_port: got rn=%h rm=%h expected DEAD/BEEF", rn_data, rm_data);
    end
    register[6] = 64'hBEEF;
    wr_en = 1'b0;
  endtask

  task automatic test_stall();
    register[2] = 64'hA;
    register[9] = 64'h99;
    rn_addr = 5'd2; rm_addr = 5'd3; rd_valid = 1'b1;
    tick();
    checks++;
    if (rn_data !== 64'hA || rm_data !== 64'h11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_pre: got rn=%h rm=%h v=%b expected A/11/1", rn_data, rm_data, out_valid);
    end
    stall = 1'b1; rn_addr = 5'd9; rm_addr = 5'd9; rd_valid = 1'b0;
    tick();
    checks++;
    if (rn_data !== 64'hA || rm_data !== 64'h11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold1: got rn=%h rm=%h v=%b expected A/11/1", rn_data, rm_data, out_valid);
    end
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hB;
    tick();
    checks++;
    if (rn_data !== 64'hB || rm_data !== 64'h11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_refresh: got rn=%h rm=%h v=%b expected B/11/1", rn_data, rm_data, out_valid);
    end
    register[2] = 64'hB; wr_en = 1'b0;
    tick();
    checks++;
    if (rn_data !== 64'hB || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold3: got rn=%h v=%b expected B/1", rn_data, out_valid);
    end
    stall = 1'b0; rd_valid = 1'b1;
    tick();
    checks++;
    if (rn_data !== 64'h99 || rm_data !== 64'h99 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_resume: got rn=%h rm=%h v=%b expected 99/99/1", rn_data, rm_data, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    register[1] = 64'h101; register[2] = 64'h102; register[3] = 64'h103;
    rd_valid = 1'b1;
    rn_addr = 5'd1; rm_addr = 5'd3;
    tick();
    checks++;
    if (rn_data !== 64'h101 || rm_data !== 64'h103 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_1: got rn=%h rm=%h v=%b expected 101/103/1", rn_data, rm_data, out_valid);
    end
    rn_addr = 5'd2; rm_addr = 5'd2;
    tick();
    checks++;
    if (rn_data !== 64'h102 || rm_data !== 64'h102 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_2: got rn=%h rm=%h v=%b expected 102/102/1", rn_data, rm_data, out_valid);
    end
    rn_addr = 5'd3; rm_addr = 5'd1;
    tick();
    checks++;
    if (rn_data !== 64'h103 || rm_data !== 64'h101 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_3: got rn=%h rm=%h v=%b expected 103/101/1", rn_data, rm_data, out_valid);
    end
    rd_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    rd_valid = 1'b1; rn_addr = 5'd3; rm_addr = 5'd1;
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if (rn_data !== 64'h103 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rms_held: got rn=%h v=%b expected 103/1", rn_data, out_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (rn_data !== 64'h0 || rm_data !== 64'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rms_reset: got rn=%h rm=%h v=%b expected 0/0/0", rn_data, rm_data, out_valid);
    end
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h333;
    tick();
    checks++;
    if (rn_data !== 64'h0 || rm_data !== 64'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rms_stall_after: got rn=%h rm=%h v=%b expected 0/0/0", rn_data, rm_data, out_valid);
    end
    wr_en = 1'b0;
    stall = 1'b0;
    tick();
    checks++;
    if (rn_data !== 64'h103 || rm_data !== 64'h101 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rms_resume: got rn=%h rm=%h v=%b expected 103/101/1", rn_data, rm_data, out_valid);
    end
  endtask

  initial begin
    register = '0;
    reset = 1'b1; rd_valid = 1'b0; stall = 1'b0;
    rn_addr = '0; rm_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_basic_read();
    test_zero_reg();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_read_port

// File: doc/regfile_read_port.md
# regfile_read_port

Read side of the 32 x 64-bit register bank. Accepts two source-register addresses per cycle (Rn, Rm) and returns both operands one cycle later through a registered, stallable output stage. Sits between the decode logic and the execute stage of the pipeline. It provides:
- write-to-read bypass for the write committed in the same cycle;
- a hardwired zero for register 31;
- in-place refresh of held operands while stalled.

## Interface
Parameters:
- DATA_W, 64, register width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- reset  in  1  synchronous, active-high
- register  in  [31:0][DATA_W-1:0]  current contents of the register bank (entry 31 is ignored)
- rd_valid  in  1  a read request is presented this cycle
- rn_addr  in  ADDR_W  first source register
- rm_addr  in  ADDR_W  second source register
- stall  in  1  downstream not accepting; hold the output stage
- wr_en  in  1  bank write committing at this clock edge
- wr_addr  in  ADDR_W  destination of that write
- wr_data  in  DATA_W  data of that write
- rn_data  out  DATA_W  registered Rn operand
- rm_data  out  DATA_W  registered Rm operand
- out_valid  out  1  rn_data/rm_data hold a valid request

## Operation
- Operand select, per port, with addr = captured address:
  - addr == 31 gives 0, always, including when wr_en targets 31.
  - Otherwise, wr_en && wr_addr == addr gives wr_data (bypass; the bank updates only at this same edge).
  - Otherwise, register[addr].
- Not stalled (stall == 0), at each edge:
  - Capture rn_addr/rm_addr into the held-address registers.
  - Load rn_data/rm_data with the selected operands of the new addresses.
  - out_valid <= rd_valid.
- Stalled (stall == 1):
  - Held addresses and out_valid are unchanged.
  - New rn_addr/rm_addr/rd_valid are ignored; the source holds them.
  - Each data register reloads from the operand select of its held address. A write that lands during a stall therefore updates the held operand, so a stalled instruction never leaves with stale data.
- Rn == Rm is legal. Both ports return identical data, including under bypass.
- rd_valid == 0 with stall == 0: out_valid drops to 0. The data registers still load (don't-care contents).
- No arithmetic and no width changes; data passes through at DATA_W bits.

## Timing
- Latency: 1 cycle. Request at edge N is presented on rn_data/rm_data/out_valid after edge N+1.
- Throughput: one request per cycle when stall == 0.
- Bypass is same-cycle. A write and a read of the same register at the same edge returns the new value; no extra cycle, no bubble.
- Stall takes effect at the edge where it is sampled high. Outputs resume updating from new inputs at the first edge where stall is sampled low.
- Reset has priority over stall and wr_en. After a reset edge:
  - out_valid = 0;
  - rn_data = rm_data = 0;
  - both held addresses = 31, so any post-reset stall holds zero.
- Reset asserted mid-stall discards the held request; there is no replay.

## Structure
- Package regfile_pkg:
  - REG_W = 64, NUM_REGS = 32, ZERO_REG = 5'd31;
  - typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [63:0]).
  - The write side of the register bank shares this package.
- Sub-module regfile_operand_sel: combinational 32:1 select with the zero-register and bypass rules. Instantiated twice (Rn, Rm).
- Top level holds only the held-address registers, the data registers, out_valid and the stall muxing.

## Test plan
- Reset, then read Rn=3, Rm=7 with register[3]=64'h11, register[7]=64'h22 -> one cycle later rn_data=64'h11, rm_data=64'h22, out_valid=1.
- Read Rn=31, Rm=31 while wr_en=1, wr_addr=31, wr_data=64'hFFFF -> rn_data=rm_data=0.
- Same edge: wr_en=1, wr_addr=5, wr_data=64'hDEAD, read Rn=5, Rm=5 while register[5]=64'h1 -> rn_data=rm_data=64'hDEAD (bypass).
- Read Rn=2 (register[2]=64'hA), assert stall for 3 cycles, write 64'hB to X2 in the 2nd stall cycle -> rn_data=64'hA, then 64'hB; out_valid stays 1; new addresses presented during the stall are ignored.
- Back-to-back reads Rn=1,2,3 with no stall, rd_valid dropped on the 4th cycle -> outputs register[1],[2],[3] on consecutive cycles, then out_valid=0.
- Stall with a valid held request, assert reset for 1 cycle -> out_valid=0, rn_data=rm_data=0. A following stall with no new request keeps the outputs at 0.
